// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: glyph table (active-high g..a), blank pattern, capture FSM states.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry i is the active-high g..a pattern for hex digit i; the encoder side uses the same table.
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    S_WAIT,
    S_SETTLE,
    S_HELD
  } cap_state_t;

endpackage

// File: rtl/seven_seg_glyph_decode.sv
// Active-low segment pattern to hex nibble; unknown or blank glyphs give nibble 0 with err set.
// Purely combinational, no backpressure.
module seven_seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       err
);

  logic [6:0] seg;

  assign seg = ~seg_n;

  always_comb begin
    nibble = '0;
    err    = 1'b1;
    if (seg != SEG_BLANK) begin
      for (int i = 0; i < 16; i++) begin
        if (seg == GLYPH_TBL[i]) begin
          nibble = 4'(i);
          err    = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus and emits them as frames.
// Latency: pins -> capture 2+STABLE_CYCLES-1 cycles; last capture -> out_valid next cycle.
// Backpressure: one output slot; frames completing while it is busy set sticky overrun.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_digits,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [6:0]              seg_s1, seg_s2, lat_seg, lat_seg_nxt;
  logic [NUM_DIGITS-1:0]   an_s1, an_s2, lat_an, lat_an_nxt;
  cap_state_t              state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    one_hot, same, restart, cap;
  logic [3:0]              nib;
  logic                    nib_err;
  logic [NUM_DIGITS-1:0]   seen, seen_nxt, sh_err, sh_err_nxt;
  logic [4*NUM_DIGITS-1:0] sh_dig, sh_dig_nxt;
  logic                    full, slot_free;

  assign one_hot = $onehot(~an_s2);
  assign same    = (an_s2 == lat_an) && (seg_s2 == lat_seg);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    lat_an_nxt  = lat_an;
    lat_seg_nxt = lat_seg;
    cap         = 1'b0;
    restart     = 1'b0;
    case (state)
      S_WAIT: restart = 1'b1;
      S_SETTLE: begin
        if (same) begin
          if (cnt != STABLE_C) cnt_nxt = cnt + CNT_ONE;
          if (cnt + CNT_ONE == STABLE_C) begin
            cap       = 1'b1;
            state_nxt = S_HELD;
          end
        end else begin
          restart = 1'b1;
        end
      end
      S_HELD:  if (!same) restart = 1'b1;
      default: restart = 1'b1;
    endcase
    // A fresh one-hot sample starts a new dwell; anything else parks in S_WAIT.
    if (restart) begin
      if (one_hot) begin
        lat_an_nxt  = an_s2;
        lat_seg_nxt = seg_s2;
        cnt_nxt     = CNT_ONE;
        if (STABLE_C == CNT_ONE) begin
          cap       = 1'b1;
          state_nxt = S_HELD;
        end else begin
          state_nxt = S_SETTLE;
        end
      end else begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
      end
    end
  end

  // Decoding the next latch value lets a single-cycle dwell capture in the same cycle.
  seven_seg_glyph_decode u_decode (
    .seg_n  (lat_seg_nxt),
    .nibble (nib),
    .err    (nib_err)
  );

  always_comb begin
    sh_dig_nxt = sh_dig;
    sh_err_nxt = sh_err;
    seen_nxt   = seen;
    if (cap) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!an_s2[i]) begin
          sh_dig_nxt[4*i +: 4] = nib;
          sh_err_nxt[i]        = nib_err;
          seen_nxt[i]          = 1'b1;
        end
      end
    end
  end

  assign full      = &seen_nxt;
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1  <= 7'h7F;
      seg_s2  <= 7'h7F;
      an_s1   <= '1;
      an_s2   <= '1;
      state   <= S_WAIT;
      cnt     <= '0;
      lat_an  <= '1;
      lat_seg <= 7'h7F;
    end else begin
      seg_s1  <= seg_n;
      seg_s2  <= seg_s1;
      an_s1   <= an_n;
      an_s2   <= an_s1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      lat_an  <= lat_an_nxt;
      lat_seg <= lat_seg_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_digits <= '0;
      out_err    <= '0;
      overrun    <= 1'b0;
      seen       <= '0;
      sh_dig     <= '0;
      sh_err     <= '0;
    end else begin
      sh_dig <= sh_dig_nxt;
      sh_err <= sh_err_nxt;
      if (full && slot_free) begin
        out_valid  <= 1'b1;
        out_digits <= sh_dig_nxt;
        out_err    <= sh_err_nxt;
        seen       <= '0;
      end else begin
        seen <= seen_nxt;
        if (full) overrun <= 1'b1;
        else if (out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scenarios plus random bus activity against a cycle reference model.
module tb_seven_seg_capture;

  localparam int N  = 4;
  localparam int SC = 4;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic [6:0]     seg_n     = 7'h7F;
  logic [N-1:0]   an_n      = '1;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [4*N-1:0] out_digits;
  logic [N-1:0]   out_err;
  logic           overrun;

  always #5 clk = ~clk;

  seven_seg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digits (out_digits),
    .out_err    (out_err),
    .overrun    (overrun)
  );

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int valid_cycles = 0;
  int hs0;
  logic [4*N-1:0] last_hs_dig = '0;
  logic [N-1:0]   last_hs_err = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 2-deep pin delay, run length of identical one-hot samples, frame slot.
  logic [6:0]     m_seg_q [2];
  logic [N-1:0]   m_an_q  [2];
  int             m_run = 0;
  logic [6:0]     m_last_seg;
  logic [N-1:0]   m_last_an;
  logic [N-1:0]   m_seen;
  logic [3:0]     m_dig [N];
  logic [N-1:0]   m_derr;
  logic           m_valid;
  logic [4*N-1:0] m_out_dig;
  logic [N-1:0]   m_out_err;
  logic           m_ovr;

  function automatic logic [4:0] ref_decode(input logic [6:0] pat);
    for (int v = 0; v < 16; v++)
      if (glyph[v] == pat) return {1'b0, 4'(v)};
    return 5'b10000;
  endfunction

  task automatic model_step();
    logic [6:0]   s_seg;
    logic [N-1:0] s_an;
    logic [4:0]   d;
    bit           oh;
    if (rst) begin
      for (int q = 0; q < 2; q++) begin
        m_seg_q[q] = 7'h7F;
        m_an_q[q]  = '1;
      end
      for (int i = 0; i < N; i++) m_dig[i] = 4'h0;
      m_run = 0; m_seen = '0; m_derr = '0; m_valid = 1'b0;
      m_out_dig = '0; m_out_err = '0; m_ovr = 1'b0;
      return;
    end
    s_seg = ~m_seg_q[1];
    s_an  = m_an_q[1];
    oh = ($countones(~s_an) == 1);
    if (!oh) m_run = 0;
    else if (m_run > 0 && ~s_seg == m_last_seg && s_an == m_last_an) m_run = (m_run < 1000) ? m_run + 1 : m_run;
    else m_run = 1;
    m_last_seg = ~s_seg;
    m_last_an  = s_an;
    if (oh && m_run == SC) begin
      d = ref_decode(s_seg);
      for (int i = 0; i < N; i++)
        if (!s_an[i]) begin
          m_dig[i] = d[3:0]; m_derr[i] = d[4]; m_seen[i] = 1'b1;
        end
    end
    if (&m_seen) begin
      if (!m_valid || out_ready) begin
        m_valid = 1'b1;
        for (int i = 0; i < N; i++) m_out_dig[4*i +: 4] = m_dig[i];
        m_out_err = m_derr;
        m_seen = '0;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    m_seg_q[1] = m_seg_q[0]; m_an_q[1] = m_an_q[0];
    m_seg_q[0] = seg_n;      m_an_q[0] = an_n;
  endtask

  task automatic tick();
    if (out_valid === 1'b1 && out_ready) begin
      hs_cnt++;
      last_hs_dig = out_digits;
      last_hs_err = out_err;
    end
    model_step();
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) valid_cycles++;
    chk("valid", 32'(out_valid), 32'(m_valid));
    chk("digits", 32'(out_digits), 32'(m_out_dig));
    chk("err", 32'(out_err), 32'(m_out_err));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic show(input int d, input logic [6:0] pat, input int cyc);
    an_n  = ~(N'(1) << d);
    seg_n = ~pat;
    repeat (cyc) tick();
  endtask

  task automatic idle(input int cyc);
    an_n  = '1;
    seg_n = 7'h7F;
    repeat (cyc) tick();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_digits", 32'(out_digits), 0);
    rst = 1'b0;
    valid_cycles = 0;
    idle(50);
    chk("idle_valid_cycles", valid_cycles, 0);
    chk("idle_overrun", 32'(overrun), 0);

    out_ready = 1'b1;
    hs0 = hs_cnt; valid_cycles = 0;
    show(0, 7'h3F, 10); show(1, 7'h06, 10); show(2, 7'h5B, 10); show(3, 7'h4F, 10);
    idle(5);
    chk("frame_count", hs_cnt - hs0, 1);
    chk("frame_pulse", valid_cycles, 1);
    chk("frame_digits", 32'(last_hs_dig), 32'h3210);
    chk("frame_err", 32'(last_hs_err), 0);

    hs0 = hs_cnt;
    show(0, 7'h6D, 10); show(1, 7'h7D, 10); show(2, 7'h77, 3); show(3, 7'h7F, 10);
    chk("glitch_no_frame", hs_cnt - hs0, 0);
    show(2, 7'h07, 10);
    idle(3);
    chk("glitch_frame", hs_cnt - hs0, 1);
    chk("glitch_digits", 32'(last_hs_dig), 32'h8765);

    hs0 = hs_cnt;
    show(0, 7'h06, 10); show(1, 7'h49, 10); show(2, 7'h5B, 10); show(3, 7'h4F, 10);
    idle(3);
    chk("illegal_frame", hs_cnt - hs0, 1);
    chk("illegal_digits", 32'(last_hs_dig), 32'h3201);
    chk("illegal_err", 32'(last_hs_err), 32'b0010);

    hs0 = hs_cnt;
    show(0, 7'h3F, 10); show(1, 7'h06, 10); show(2, 7'h5B, 10);
    an_n = 4'b0110; seg_n = ~7'h3F;
    repeat (20) tick();
    idle(5);
    chk("multi_no_frame", hs_cnt - hs0, 0);
    show(3, 7'h66, 10);
    idle(3);
    chk("multi_frame", hs_cnt - hs0, 1);
    chk("multi_digits", 32'(last_hs_dig), 32'h4210);

    out_ready = 1'b0;
    hs0 = hs_cnt;
    show(0, 7'h67, 10); show(1, 7'h77, 10); show(2, 7'h7C, 10); show(3, 7'h39, 10);
    show(0, 7'h5E, 10); show(1, 7'h79, 10); show(2, 7'h71, 10); show(3, 7'h3F, 10);
    idle(3);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_hold", 32'(out_digits), 32'hCBA9);
    chk("bp_overrun", 32'(overrun), 1);
    out_ready = 1'b1;
    tick();
    chk("bp_next_valid", 32'(out_valid), 1);
    chk("bp_next_digits", 32'(out_digits), 32'h0FED);
    tick();
    chk("bp_drain", 32'(out_valid), 0);
    chk("bp_handshakes", hs_cnt - hs0, 2);

    out_ready = 1'b0;
    show(0, 7'h06, 10); show(1, 7'h5B, 10); show(2, 7'h4F, 10); show(3, 7'h66, 10);
    show(0, 7'h6D, 2);
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_digits", 32'(out_digits), 0);
    chk("midrst_err", 32'(out_err), 0);
    chk("midrst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    hs0 = hs_cnt;
    show(1, 7'h7D, 10); show(2, 7'h7F, 10); show(3, 7'h67, 10);
    idle(3);
    chk("postrst_no_frame", hs_cnt - hs0, 0);
    show(0, 7'h07, 10);
    idle(3);
    chk("postrst_frame", hs_cnt - hs0, 1);
    chk("postrst_digits", 32'(last_hs_dig), 32'h9867);

    for (int k = 0; k < 400; k++) begin
      int r;
      int dw;
      r  = $urandom_range(0, 99);
      dw = $urandom_range(1, 7);
      rst = (r < 3);
      if (r < 12) an_n = N'($urandom);
      else an_n = ~(N'(1) << $urandom_range(0, N - 1));
      if ($urandom_range(0, 4) == 0) seg_n = 7'($urandom);
      else seg_n = ~glyph[$urandom_range(0, 15)];
      for (int c = 0; c < dw; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      rst = 1'b0;
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
